dmi_req_sequencer: RTL and testbench
====================================

Name: dmi_req_sequencer

Overview:
- Sits between the simulation DMI socket bridge and the debug module's DMI port.
- Buffers incoming DMI requests and issues them one at a time, so only one request is ever outstanding.
- Enforces a programmable quiet gap after every write, replacing the bridge's ad-hoc write delay.
- Bounds every transaction with a response timeout and returns exactly one response upstream per accepted request.

Parameters:
FIFO_DEPTH, 4, request FIFO entries (power of two, >=2)
WRITE_GAP, 200, idle cycles after a write's response is returned upstream
TIMEOUT, 1024, max cycles to wait for a debug-module response
ADDR_W, 7, DMI address width

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
up_req_valid  in  1  request from socket bridge
up_req_ready  out  1  FIFO not full
up_req_addr  in  ADDR_W  request address
up_req_op  in  2  0 nop, 1 read, 2 write, 3 reserved
up_req_data  in  32  write data
up_resp_valid  out  1  response to socket bridge
up_resp_ready  in  1  bridge accepts response
up_resp_resp  out  2  0 ok, 2 failed, 3 busy
up_resp_data  out  32  read data
dm_req_valid  out  1  request to debug module
dm_req_ready  in  1  debug module accepts
dm_req_addr  out  ADDR_W  address
dm_req_op  out  2  op
dm_req_data  out  32  data
dm_resp_valid  in  1  debug-module response
dm_resp_ready  out  1  always 1 after reset
dm_resp_resp  in  2  response code
dm_resp_data  in  32  response data
timeout_cnt  out  8  saturating count of timed-out requests
stray_cnt  out  8  saturating count of responses seen outside WAIT_RESP

Behaviour:
- Reset (async, reset_n=0): FIFO empty; FSM IDLE; all valids 0; dm_req_addr/op/data 0; up_resp_resp/data 0; counters 0; dm_resp_ready 0. dm_resp_ready becomes 1 on the first clock after reset deasserts.
- All outputs are registered except up_req_ready, which is defined as !full.
- FIFO:
  - Push on up_req_valid && up_req_ready.
  - Pop when the FSM leaves IDLE with a head entry.
  - A simultaneous push and pop when full is not allowed, because ready is low.
  - Pointers wrap modulo FIFO_DEPTH; an extra wrap bit distinguishes full from empty.
- FSM states: IDLE, ISSUE, WAIT_RESP, RETURN, GAP.
- IDLE, FIFO not empty:
  - Pop the head.
  - If op==3: load up_resp_resp=2 and up_resp_data=0, then go to RETURN. Nothing is sent downstream.
  - Otherwise: load dm_req_*, set dm_req_valid=1, go to ISSUE.
  - Latency: a request pushed at edge N shows dm_req_valid at edge N+2, provided the FSM was idle.
- ISSUE:
  - Hold dm_req_* stable until dm_req_ready is sampled high.
  - Then clear dm_req_valid, clear the timer, and go to WAIT_RESP.
  - The TIMEOUT count does not apply in ISSUE; ISSUE stalls indefinitely.
- WAIT_RESP:
  - On dm_resp_valid: capture resp/data into up_resp_*, go to RETURN.
  - If the timer reaches TIMEOUT-1 with no response: up_resp_resp=2, up_resp_data=0, timeout_cnt++, go to RETURN.
  - If a response arrives on the timeout cycle, the real response wins.
- RETURN:
  - up_resp_valid=1 until up_resp_ready is sampled.
  - Then: if the issued op==2, load the gap counter with WRITE_GAP and go to GAP; otherwise go to IDLE.
  - A rejected op==3 does not trigger a gap.
- GAP: decrement each cycle; go to IDLE on the cycle the counter reaches 0. WRITE_GAP=0 bypasses GAP entirely.
- Stray responses: a dm_resp_valid in any state other than WAIT_RESP is consumed, dropped, and increments stray_cnt. Both counters saturate at 255.
- The FIFO continues to accept pushes in every state.
- Reset mid-transaction: everything is discarded; no response is emitted upstream.

Decomposition:
- Shared package dmi_pkg:
  - dmi_op_e (NOP/READ/WRITE/RSVD)
  - dmi_resp_e (OK=0, FAILED=2, BUSY=3)
  - dmi_req_t struct {addr, op, data}
  - DMI_ADDR_W constant
- One sub-module, dmi_req_fifo: a parameterised synchronous FIFO with async active-low reset, carrying dmi_req_t with push/pop/full/empty.

Test Plan:
- Read: push addr=0x11 op=1 → dm_req_valid at the second edge after the push. dm returns resp=0 data=0xDEADBEEF after 3 cycles → up_resp_valid with resp=0 data=0xDEADBEEF; the next request issues immediately.
- Write gap: push write addr=0x10 data=1, then a read, with WRITE_GAP=200 → the read's dm_req_valid rises exactly 201 cycles after the write's up_resp handshake (200 GAP cycles plus the IDLE issue cycle).
- Timeout: TIMEOUT=16, dm never responds → up_resp resp=2 data=0 after 16 WAIT_RESP cycles; timeout_cnt=1. A late response afterwards → stray_cnt=1.
- Backpressure/full: hold dm_req_ready=0, push 5 requests with FIFO_DEPTH=4 → up_req_ready drops after the FIFO fills (one entry is already issued); order is preserved when released.
- Reserved op: push op=3 → resp=2 returned, no dm_req_valid pulse, no gap.
- Async reset during WAIT_RESP → all outputs at reset values with no clock edge; no up_resp_valid afterwards.

Source files
------------

// File: rtl/dmi_pkg.sv
// Shared DMI types: operation and response codes, the request payload,
// and the sequencer FSM state encoding.
package dmi_pkg;

  localparam int unsigned DMI_ADDR_W = 7;
  localparam int unsigned DMI_DATA_W = 32;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_RSVD  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    RESP_OK     = 2'd0,
    RESP_FAILED = 2'd2,
    RESP_BUSY   = 2'd3
  } dmi_resp_e;

  typedef struct packed {
    logic [DMI_ADDR_W-1:0] addr;
    dmi_op_e               op;
    logic [DMI_DATA_W-1:0] data;
  } dmi_req_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RESP,
    ST_RETURN,
    ST_GAP
  } seq_state_e;

endpackage

// File: rtl/dmi_req_fifo.sv
// Request FIFO for DMI requests; pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate count.
module dmi_req_fifo
  import dmi_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clock,
  input  logic     reset_n,
  input  logic     push,
  input  dmi_req_t wdata,
  input  logic     pop,
  output dmi_req_t head,
  output logic     full,
  output logic     empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  dmi_req_t         mem [DEPTH];
  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + CNT_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + CNT_W'(1);
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/dmi_req_sequencer.sv
// Serialises DMI requests toward the debug module: one outstanding request,
// response timeout, quiet gap after writes, one upstream response per request.
module dmi_req_sequencer
  import dmi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WRITE_GAP  = 200,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned ADDR_W     = DMI_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              up_req_valid,
  output logic              up_req_ready,
  input  logic [ADDR_W-1:0] up_req_addr,
  input  logic [1:0]        up_req_op,
  input  logic [31:0]       up_req_data,
  output logic              up_resp_valid,
  input  logic              up_resp_ready,
  output logic [1:0]        up_resp_resp,
  output logic [31:0]       up_resp_data,
  output logic              dm_req_valid,
  input  logic              dm_req_ready,
  output logic [ADDR_W-1:0] dm_req_addr,
  output logic [1:0]        dm_req_op,
  output logic [31:0]       dm_req_data,
  input  logic              dm_resp_valid,
  output logic              dm_resp_ready,
  input  logic [1:0]        dm_resp_resp,
  input  logic [31:0]       dm_resp_data,
  output logic [7:0]        timeout_cnt,
  output logic [7:0]        stray_cnt
);

  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned GAP_W = (WRITE_GAP > 1) ? $clog2(WRITE_GAP + 1) : 1;

  seq_state_e       state;
  dmi_op_e          cur_op;
  logic [TMR_W-1:0] timer;
  logic [GAP_W-1:0] gap_cnt;

  dmi_req_t fifo_wdata;
  dmi_req_t fifo_head;
  logic     fifo_full;
  logic     fifo_empty;
  logic     fifo_push;
  logic     fifo_pop;

  assign up_req_ready = !fifo_full;
  assign fifo_push    = up_req_valid && !fifo_full;
  assign fifo_pop     = (state == ST_IDLE) && !fifo_empty;
  assign fifo_wdata   = '{addr: DMI_ADDR_W'(up_req_addr),
                          op:   dmi_op_e'(up_req_op),
                          data: up_req_data};

  dmi_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wdata   (fifo_wdata),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      cur_op        <= OP_NOP;
      timer         <= '0;
      gap_cnt       <= '0;
      up_resp_valid <= 1'b0;
      up_resp_resp  <= 2'd0;
      up_resp_data  <= '0;
      dm_req_valid  <= 1'b0;
      dm_req_addr   <= '0;
      dm_req_op     <= 2'd0;
      dm_req_data   <= '0;
      dm_resp_ready <= 1'b0;
      timeout_cnt   <= '0;
      stray_cnt     <= '0;
    end else begin
      dm_resp_ready <= 1'b1;

      // Responses arriving while nothing is outstanding are dropped and counted.
      if (dm_resp_valid && dm_resp_ready && (state != ST_WAIT_RESP) &&
          (stray_cnt != 8'hFF)) begin
        stray_cnt <= stray_cnt + 8'd1;
      end

      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cur_op <= fifo_head.op;
            if (fifo_head.op == OP_RSVD) begin
              up_resp_valid <= 1'b1;
              up_resp_resp  <= RESP_FAILED;
              up_resp_data  <= '0;
              state         <= ST_RETURN;
            end else begin
              dm_req_valid <= 1'b1;
              dm_req_addr  <= ADDR_W'(fifo_head.addr);
              dm_req_op    <= fifo_head.op;
              dm_req_data  <= fifo_head.data;
              state        <= ST_ISSUE;
            end
          end
        end

        ST_ISSUE: begin
          if (dm_req_ready) begin
            dm_req_valid <= 1'b0;
            timer        <= '0;
            state        <= ST_WAIT_RESP;
          end
        end

        // A response on the expiry cycle takes priority over the timeout.
        ST_WAIT_RESP: begin
          if (dm_resp_valid) begin
            up_resp_valid <= 1'b1;
            up_resp_resp  <= dm_resp_resp;
            up_resp_data  <= dm_resp_data;
            state         <= ST_RETURN;
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            up_resp_valid <= 1'b1;
            up_resp_resp  <= RESP_FAILED;
            up_resp_data  <= '0;
            if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
            state         <= ST_RETURN;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        ST_RETURN: begin
          if (up_resp_ready) begin
            up_resp_valid <= 1'b0;
            if ((cur_op == OP_WRITE) && (WRITE_GAP != 0)) begin
              gap_cnt <= GAP_W'(WRITE_GAP);
              state   <= ST_GAP;
            end else begin
              state <= ST_IDLE;
            end
          end
        end

        ST_GAP: begin
          gap_cnt <= gap_cnt - GAP_W'(1);
          if (gap_cnt == GAP_W'(1)) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmi_req_sequencer.sv
// Directed bench for dmi_req_sequencer: a cycle table for the basic read and
// reserved-op flows plus sequences for gap, timeout, backpressure and reset.
module tb_dmi_req_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        up_req_valid = 1'b0;
  logic        up_req_ready;
  logic [6:0]  up_req_addr = '0;
  logic [1:0]  up_req_op = '0;
  logic [31:0] up_req_data = '0;
  logic        up_resp_valid;
  logic        up_resp_ready = 1'b0;
  logic [1:0]  up_resp_resp;
  logic [31:0] up_resp_data;
  logic        dm_req_valid;
  logic        dm_req_ready = 1'b0;
  logic [6:0]  dm_req_addr;
  logic [1:0]  dm_req_op;
  logic [31:0] dm_req_data;
  logic        dm_resp_valid = 1'b0;
  logic        dm_resp_ready;
  logic [1:0]  dm_resp_resp = '0;
  logic [31:0] dm_resp_data = '0;
  logic [7:0]  timeout_cnt;
  logic [7:0]  stray_cnt;

  int nvec = 0;
  int nerr = 0;

  dmi_req_sequencer #(
    .FIFO_DEPTH (4),
    .WRITE_GAP  (200),
    .TIMEOUT    (16),
    .ADDR_W     (7)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .up_req_valid  (up_req_valid),
    .up_req_ready  (up_req_ready),
    .up_req_addr   (up_req_addr),
    .up_req_op     (up_req_op),
    .up_req_data   (up_req_data),
    .up_resp_valid (up_resp_valid),
    .up_resp_ready (up_resp_ready),
    .up_resp_resp  (up_resp_resp),
    .up_resp_data  (up_resp_data),
    .dm_req_valid  (dm_req_valid),
    .dm_req_ready  (dm_req_ready),
    .dm_req_addr   (dm_req_addr),
    .dm_req_op     (dm_req_op),
    .dm_req_data   (dm_req_data),
    .dm_resp_valid (dm_resp_valid),
    .dm_resp_ready (dm_resp_ready),
    .dm_resp_resp  (dm_resp_resp),
    .dm_resp_data  (dm_resp_data),
    .timeout_cnt   (timeout_cnt),
    .stray_cnt     (stray_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        iv;
    logic [6:0]  ia;
    logic [1:0]  iop;
    logic [31:0] idat;
    logic        drdy;
    logic        rv;
    logic [1:0]  rr;
    logic [31:0] rd;
    logic        urdy;
    logic        e_dv;
    logic [6:0]  e_da;
    logic        e_uv;
    logic [1:0]  e_ur;
    logic [31:0] e_ud;
    logic        e_rdy;
  } vec_t;

  function automatic vec_t mk(int iv, int ia, int iop, int idat, int drdy,
                              int rv, int rr, int rd, int urdy, int e_dv,
                              int e_da, int e_uv, int e_ur, int e_ud, int e_rdy);
    vec_t v;
    v.iv = 1'(iv);     v.ia = 7'(ia);     v.iop = 2'(iop);   v.idat = 32'(idat);
    v.drdy = 1'(drdy); v.rv = 1'(rv);     v.rr = 2'(rr);     v.rd = 32'(rd);
    v.urdy = 1'(urdy); v.e_dv = 1'(e_dv); v.e_da = 7'(e_da); v.e_uv = 1'(e_uv);
    v.e_ur = 2'(e_ur); v.e_ud = 32'(e_ud); v.e_rdy = 1'(e_rdy);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_dm(input string name);
    int n = 0;
    while (!dm_req_valid && n < 500) begin
      step();
      n++;
    end
    chk({name, "_dm_valid"}, 32'(dm_req_valid), 32'd1);
  endtask

  // Issue, answer and hand back one request whose downstream copy is expected.
  task automatic serve(input string name, input logic [6:0] addr,
                       input logic [1:0] op, input logic [31:0] rdata);
    wait_dm(name);
    chk({name, "_dm_addr"}, 32'(dm_req_addr), 32'(addr));
    chk({name, "_dm_op"}, 32'(dm_req_op), 32'(op));
    dm_req_ready = 1'b1;
    step();
    dm_req_ready  = 1'b0;
    dm_resp_valid = 1'b1;
    dm_resp_resp  = 2'd0;
    dm_resp_data  = rdata;
    step();
    dm_resp_valid = 1'b0;
    chk({name, "_up_valid"}, 32'(up_resp_valid), 32'd1);
    chk({name, "_up_data"}, up_resp_data, rdata);
    up_resp_ready = 1'b1;
    step();
    up_resp_ready = 1'b0;
  endtask

  task automatic push(input logic [6:0] addr, input logic [1:0] op, input logic [31:0] data);
    up_req_valid = 1'b1;
    up_req_addr  = addr;
    up_req_op    = op;
    up_req_data  = data;
    step();
    up_req_valid = 1'b0;
  endtask

  vec_t vecs[19];

  initial begin
    int n;
    logic saw;

    // Read, next-request issue, reserved op, and a non-gapped follow-up read.
    vecs[0]  = mk(1, 'h11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h11, 0, 0, 0, 1);
    vecs[2]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[3]  = mk(1, 'h22, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[5]  = mk(0, 0, 0, 0, 0, 1, 0, 'hDEADBEEF, 0, 0, 0, 1, 0, 'hDEADBEEF, 1);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h22, 0, 0, 0, 1);
    vecs[8]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[9]  = mk(0, 0, 0, 0, 0, 1, 0, 'h12345678, 0, 0, 0, 1, 0, 'h12345678, 1);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    vecs[11] = mk(1, 'h05, 3, 'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    vecs[14] = mk(1, 'h33, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h33, 0, 0, 0, 1);
    vecs[16] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[17] = mk(0, 0, 0, 0, 0, 1, 3, 'hCAFE0001, 0, 0, 0, 1, 3, 'hCAFE0001, 1);
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);

    // Reset values, observed before any clock edge.
    #1 reset_n = 1'b0;
    #1;
    chk("rst_dm_valid", 32'(dm_req_valid), 32'd0);
    chk("rst_up_valid", 32'(up_resp_valid), 32'd0);
    chk("rst_dm_addr", 32'(dm_req_addr), 32'd0);
    chk("rst_dm_op", 32'(dm_req_op), 32'd0);
    chk("rst_dm_data", dm_req_data, 32'd0);
    chk("rst_up_resp", 32'(up_resp_resp), 32'd0);
    chk("rst_up_data", up_resp_data, 32'd0);
    chk("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
    chk("rst_stray_cnt", 32'(stray_cnt), 32'd0);
    chk("rst_dm_resp_ready", 32'(dm_resp_ready), 32'd0);
    chk("rst_up_req_ready", 32'(up_req_ready), 32'd1);
    step();
    step();
    reset_n = 1'b1;
    step();
    chk("dm_resp_ready_after_rst", 32'(dm_resp_ready), 32'd1);

    for (int i = 0; i < 19; i++) begin
      up_req_valid  = vecs[i].iv;
      up_req_addr   = vecs[i].ia;
      up_req_op     = vecs[i].iop;
      up_req_data   = vecs[i].idat;
      dm_req_ready  = vecs[i].drdy;
      dm_resp_valid = vecs[i].rv;
      dm_resp_resp  = vecs[i].rr;
      dm_resp_data  = vecs[i].rd;
      up_resp_ready = vecs[i].urdy;
      step();
      chk($sformatf("row%0d_dm_valid", i), 32'(dm_req_valid), 32'(vecs[i].e_dv));
      chk($sformatf("row%0d_up_valid", i), 32'(up_resp_valid), 32'(vecs[i].e_uv));
      chk($sformatf("row%0d_up_req_ready", i), 32'(up_req_ready), 32'(vecs[i].e_rdy));
      if (vecs[i].e_dv) begin
        chk($sformatf("row%0d_dm_addr", i), 32'(dm_req_addr), 32'(vecs[i].e_da));
      end
      if (vecs[i].e_uv) begin
        chk($sformatf("row%0d_up_resp", i), 32'(up_resp_resp), 32'(vecs[i].e_ur));
        chk($sformatf("row%0d_up_data", i), up_resp_data, vecs[i].e_ud);
      end
    end
    up_req_valid = 1'b0; dm_req_ready = 1'b0; dm_resp_valid = 1'b0; up_resp_ready = 1'b0;
    chk("no_stray_so_far", 32'(stray_cnt), 32'd0);

    // Write gap: the queued read issues 201 edges after the write's handshake.
    push(7'h10, 2'd2, 32'd1);
    push(7'h12, 2'd1, 32'd0);
    wait_dm("gap_wr");
    chk("gap_wr_data", dm_req_data, 32'd1);
    serve("gap_wr", 7'h10, 2'd2, 32'd0);
    n = 0;
    while (!dm_req_valid && n < 400) begin
      step();
      n++;
    end
    chk("gap_len", 32'(n), 32'd201);
    serve("gap_rd", 7'h12, 2'd1, 32'h0000_0BAD);

    // Timeout after 16 silent cycles, then a late response counted as stray.
    push(7'h20, 2'd1, 32'd0);
    wait_dm("to");
    dm_req_ready = 1'b1;
    step();
    dm_req_ready = 1'b0;
    n = 0;
    while (!up_resp_valid && n < 100) begin
      step();
      n++;
    end
    chk("to_wait_cycles", 32'(n), 32'd16);
    chk("to_resp", 32'(up_resp_resp), 32'd2);
    chk("to_data", up_resp_data, 32'd0);
    chk("to_cnt", 32'(timeout_cnt), 32'd1);
    up_resp_ready = 1'b1;
    step();
    up_resp_ready = 1'b0;
    dm_resp_valid = 1'b1;
    dm_resp_data  = 32'h1111_2222;
    step();
    dm_resp_valid = 1'b0;
    chk("stray_cnt", 32'(stray_cnt), 32'd1);
    chk("stray_no_resp", 32'(up_resp_valid), 32'd0);

    // Response on the final timeout cycle wins over the timeout.
    push(7'h21, 2'd1, 32'd0);
    wait_dm("tow");
    dm_req_ready = 1'b1;
    step();
    dm_req_ready = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("tow_pending", 32'(up_resp_valid), 32'd0);
    dm_resp_valid = 1'b1;
    dm_resp_resp  = 2'd0;
    dm_resp_data  = 32'hA5A5_A5A5;
    step();
    dm_resp_valid = 1'b0;
    chk("tow_valid", 32'(up_resp_valid), 32'd1);
    chk("tow_resp", 32'(up_resp_resp), 32'd0);
    chk("tow_data", up_resp_data, 32'hA5A5_A5A5);
    chk("tow_cnt", 32'(timeout_cnt), 32'd1);
    up_resp_ready = 1'b1;
    step();
    up_resp_ready = 1'b0;

    // Backpressure: first entry is popped into ISSUE, four more fill the FIFO.
    for (int i = 0; i < 5; i++) begin
      push(7'(8'h40 + 8'(i)), 2'd1, 32'd0);
      chk($sformatf("bp_ready%0d", i), 32'(up_req_ready), (i < 4) ? 32'd1 : 32'd0);
    end
    push(7'h7F, 2'd1, 32'd0);
    chk("bp_full_hold", 32'(up_req_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      serve($sformatf("bp%0d", i), 7'(8'h40 + 8'(i)), 2'd1, 32'h100 + 32'(i));
    end
    step();
    chk("bp_drained", 32'(dm_req_valid), 32'd0);
    chk("bp_ready_end", 32'(up_req_ready), 32'd1);

    // Async reset while waiting for a response discards everything.
    push(7'h50, 2'd2, 32'h77);
    push(7'h51, 2'd1, 32'd0);
    wait_dm("ar");
    dm_req_ready = 1'b1;
    step();
    dm_req_ready = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    chk("ar_dm_valid", 32'(dm_req_valid), 32'd0);
    chk("ar_dm_addr", 32'(dm_req_addr), 32'd0);
    chk("ar_dm_data", dm_req_data, 32'd0);
    chk("ar_up_valid", 32'(up_resp_valid), 32'd0);
    chk("ar_cnts", 32'({timeout_cnt, stray_cnt}), 32'd0);
    chk("ar_dm_resp_ready", 32'(dm_resp_ready), 32'd0);
    step();
    reset_n = 1'b1;
    up_resp_ready = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (up_resp_valid || dm_req_valid) saw = 1'b1;
    end
    up_resp_ready = 1'b0;
    chk("ar_silent", 32'(saw), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
